// File: rtl/ame_num_div_if.sv
// ============================================================================
// Module   : ame_num_div_if
// Brief    : Init/done handshake and data bundle for the AME dual-lane divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ame_num_div_if #(
    parameter int COMP_DATA_BITS = 64,
    parameter int COMP_QUO_BITS  = 32
);
    logic                                    comp_init_i;
    logic                                    comp_busy_o;
    logic                                    comp_done_o;
    logic [$clog2(COMP_DATA_BITS)-1:0]       comp_shift_i;
    logic [$clog2(COMP_DATA_BITS)-1:0]       comp_shift_o;
    logic [3:0][COMP_DATA_BITS-1:0]          comp_data_i;
    logic [1:0][COMP_QUO_BITS-1:0]           comp_quo_o;
    logic [1:0]                              comp_dz_o;
    logic [1:0]                              comp_ovf_o;

    modport master (
        output comp_init_i, comp_shift_i, comp_data_i,
        input  comp_busy_o, comp_done_o, comp_shift_o, comp_quo_o, comp_dz_o, comp_ovf_o
    );

    modport slave (
        input  comp_init_i, comp_shift_i, comp_data_i,
        output comp_busy_o, comp_done_o, comp_shift_o, comp_quo_o, comp_dz_o, comp_ovf_o
    );
endinterface

`default_nettype wire

// File: rtl/ame_num_div.sv
// ============================================================================
// Module   : ame_num_div
// Brief    : Dual-lane restoring signed fixed-point divider (M/D, L/C), fixed
//            latency N+2, saturating output. Define AME_NUM_DIV_ROUND_EN for
//            round-half-away-from-zero instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ame_num_div #(
    parameter int COMP_DATA_BITS = 64,
    parameter int COMP_FRAC_BITS = 16,
    parameter int COMP_QUO_BITS  = 32
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    ame_num_div_if.slave     bus
);
    localparam int c_n     = COMP_DATA_BITS + COMP_FRAC_BITS;
    localparam int c_cnt_w = $clog2(c_n);
    localparam int c_sh_w  = $clog2(COMP_DATA_BITS);
    localparam int c_dw    = COMP_DATA_BITS;
    localparam int c_qw    = COMP_QUO_BITS;

    localparam logic [c_n:0]    c_neg_lim = (c_n+1)'(1) << (c_qw - 1);
    localparam logic [c_n:0]    c_pos_lim = c_neg_lim - (c_n+1)'(1);
    localparam logic [c_qw-1:0] c_q_max   = {1'b0, {(c_qw-1){1'b1}}};
    localparam logic [c_qw-1:0] c_q_min   = {1'b1, {(c_qw-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0][c_dw-1:0]   r_num;
    logic [1:0][c_dw-1:0]   r_den;
    logic [1:0][c_dw-1:0]   r_dmag;
    logic [1:0][c_n-1:0]    r_dvd;
    logic [1:0][c_dw:0]     r_rem;
    logic [1:0]             r_sign;
    logic [1:0]             r_dz;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_sh_w-1:0]      r_shift_cap;

    logic [1:0][c_qw-1:0]   r_quo;
    logic [1:0]             r_dz_o;
    logic [1:0]             r_ovf_o;
    logic [c_sh_w-1:0]      r_shift_o;
    logic                   r_done;

    logic [1:0][c_dw-1:0]   w_num_mag;
    logic [1:0][c_dw-1:0]   w_den_mag;
    logic [1:0][c_dw+1:0]   w_trial;
    logic [1:0]             w_ge;
    logic [1:0][c_dw:0]     w_rem_nxt;
    logic [1:0][c_n:0]      w_q_mag;
    logic [1:0][c_qw-1:0]   w_q_lo;
    logic [1:0]             w_ovf;
    logic [1:0][c_qw-1:0]   w_quo;

    // Per-lane datapath: lane 1 = M/D (words 3,2), lane 0 = L/C (words 1,0).
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_num_mag[l] = r_num[l][c_dw-1] ? -r_num[l] : r_num[l];
            w_den_mag[l] = r_den[l][c_dw-1] ? -r_den[l] : r_den[l];
            w_trial[l]   = {r_rem[l], r_dvd[l][c_n-1]};
            w_ge[l]      = (w_trial[l] >= {2'b00, r_dmag[l]});
            w_rem_nxt[l] = w_ge[l] ? (w_trial[l][c_dw:0] - {1'b0, r_dmag[l]})
                                   : w_trial[l][c_dw:0];
            w_q_mag[l]   = {1'b0, r_dvd[l]};
`ifdef AME_NUM_DIV_ROUND_EN
            if ({r_rem[l], 1'b0} >= {2'b00, r_dmag[l]})
                w_q_mag[l] = w_q_mag[l] + (c_n+1)'(1);
`endif
            w_q_lo[l] = w_q_mag[l][c_qw-1:0];
            w_ovf[l]  = r_sign[l] ? (w_q_mag[l] > c_neg_lim) : (w_q_mag[l] > c_pos_lim);
            if (r_dz[l]) begin
                if (r_num[l] == '0)
                    w_quo[l] = '0;
                else
                    w_quo[l] = r_num[l][c_dw-1] ? c_q_min : c_q_max;
            end else if (w_ovf[l]) begin
                w_quo[l] = r_sign[l] ? c_q_min : c_q_max;
            end else begin
                w_quo[l] = r_sign[l] ? -w_q_lo[l] : w_q_lo[l];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.comp_init_i) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_num       <= '0;
            r_den       <= '0;
            r_dmag      <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_sign      <= '0;
            r_dz        <= '0;
            r_cnt       <= '0;
            r_shift_cap <= '0;
            r_quo       <= '0;
            r_dz_o      <= '0;
            r_ovf_o     <= '0;
            r_shift_o   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.comp_init_i) begin
                        r_num[1]    <= bus.comp_data_i[3];
                        r_den[1]    <= bus.comp_data_i[2];
                        r_num[0]    <= bus.comp_data_i[1];
                        r_den[0]    <= bus.comp_data_i[0];
                        r_shift_cap <= bus.comp_shift_i;
                    end
                end
                S_LOAD: begin
                    for (int l = 0; l < 2; l++) begin
                        r_sign[l] <= r_num[l][c_dw-1] ^ r_den[l][c_dw-1];
                        r_dz[l]   <= (r_den[l] == '0);
                        r_dmag[l] <= w_den_mag[l];
                        r_dvd[l]  <= c_n'(w_num_mag[l]) << COMP_FRAC_BITS;
                        r_rem[l]  <= '0;
                    end
                    r_cnt <= c_cnt_w'(c_n - 1);
                end
                S_CALC: begin
                    // Quotient bits shift into the dividend register as it empties.
                    for (int l = 0; l < 2; l++) begin
                        r_dvd[l] <= {r_dvd[l][c_n-2:0], w_ge[l]};
                        r_rem[l] <= w_rem_nxt[l];
                    end
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                S_FIX: begin
                    r_quo     <= w_quo;
                    r_dz_o    <= r_dz;
                    r_ovf_o   <= ~r_dz & w_ovf;
                    r_shift_o <= r_shift_cap;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.comp_busy_o  = (r_state != S_IDLE);
    assign bus.comp_done_o  = r_done;
    assign bus.comp_quo_o   = r_quo;
    assign bus.comp_dz_o    = r_dz_o;
    assign bus.comp_ovf_o   = r_ovf_o;
    assign bus.comp_shift_o = r_shift_o;

endmodule

`default_nettype wire

// File: tb/tb_ame_num_div.sv
// ============================================================================
// Module   : tb_ame_num_div
// Brief    : Directed self-checking bench for ame_num_div at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ame_num_div;
    localparam int c_lat = 82;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    ame_num_div_if #(.COMP_DATA_BITS(64), .COMP_QUO_BITS(32)) u_if ();

    ame_num_div #(
        .COMP_DATA_BITS(64),
        .COMP_FRAC_BITS(16),
        .COMP_QUO_BITS (32)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (u_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge; the following edge samples the init.
    task automatic issue(input logic signed [63:0] m, input logic signed [63:0] d,
                         input logic signed [63:0] l, input logic signed [63:0] c,
                         input logic [5:0] sh);
        u_if.comp_data_i  = {m, d, l, c};
        u_if.comp_shift_i = sh;
        u_if.comp_init_i  = 1'b1;
        @(posedge clk_i);
        #1;
        u_if.comp_init_i  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int c;
        lat = -1;
        c   = 0;
        while (lat < 0 && c < 300) begin
            @(posedge clk_i);
            #1;
            c++;
            if (u_if.comp_done_o) lat = c;
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic signed [63:0] m, input logic signed [63:0] d,
                           input logic signed [63:0] l, input logic signed [63:0] c,
                           input logic [5:0] sh, input logic [31:0] e1, input logic [31:0] e0,
                           input logic [1:0] edz, input logic [1:0] eovf);
        int lat;
        issue(m, d, l, c, sh);
        check({tag, " busy"}, 64'(u_if.comp_busy_o), 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'(c_lat));
        check({tag, " busy_in_done"}, 64'(u_if.comp_busy_o), 64'd0);
        check({tag, " quo_md"}, 64'(u_if.comp_quo_o[1]), 64'(e1));
        check({tag, " quo_lc"}, 64'(u_if.comp_quo_o[0]), 64'(e0));
        check({tag, " dz"}, 64'(u_if.comp_dz_o), 64'(edz));
        check({tag, " ovf"}, 64'(u_if.comp_ovf_o), 64'(eovf));
        check({tag, " shift"}, 64'(u_if.comp_shift_o), 64'(sh));
        @(posedge clk_i);
        #1;
        check({tag, " done_pulse"}, 64'(u_if.comp_done_o), 64'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        rst_i             = 1'b1;
        u_if.comp_init_i  = 1'b0;
        u_if.comp_data_i  = '0;
        u_if.comp_shift_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst busy", 64'(u_if.comp_busy_o), 64'd0);
        check("rst done", 64'(u_if.comp_done_o), 64'd0);
        check("rst quo", 64'(u_if.comp_quo_o), 64'd0);
        check("rst dz", 64'(u_if.comp_dz_o), 64'd0);
        check("rst ovf", 64'(u_if.comp_ovf_o), 64'd0);
        check("rst shift", 64'(u_if.comp_shift_o), 64'd0);
        rst_i = 1'b0;

        run_vec("basic", 3, 2, -7, 4, 6'd5, 32'h0001_8000, 32'hFFFE_4000, 2'b00, 2'b00);
        run_vec("dz_pos", 5, 0, 0, 0, 6'd1, 32'h7FFF_FFFF, 32'h0000_0000, 2'b11, 2'b00);
        run_vec("dz_neg", -5, 0, 0, 0, 6'd2, 32'h8000_0000, 32'h0000_0000, 2'b11, 2'b00);
        run_vec("sat", 64'h0000_0100_0000_0000, 1, 64'hFFFF_FF00_0000_0000, 1, 6'd63,
                32'h7FFF_FFFF, 32'h8000_0000, 2'b00, 2'b11);
        run_vec("neg_lim", -32768, 1, 1, 1, 6'd0, 32'h8000_0000, 32'h0001_0000, 2'b00, 2'b00);
        run_vec("min_den", 1, 64'h8000_0000_0000_0000, -1, -2, 6'd7,
                32'h0000_0000, 32'h0000_8000, 2'b00, 2'b00);
`ifdef AME_NUM_DIV_ROUND_EN
        run_vec("third", 2, 3, -2, 3, 6'd9, 32'h0000_AAAB, 32'hFFFF_5555, 2'b00, 2'b00);
`else
        run_vec("third", 2, 3, -2, 3, 6'd9, 32'h0000_AAAA, 32'hFFFF_5556, 2'b00, 2'b00);
`endif

        // Inits while busy must be dropped, not queued.
        issue(3, 2, -7, 4, 6'd5);
        ndone = 0;
        lat   = -1;
        for (int c = 1; c <= c_lat + 100; c++) begin
            @(posedge clk_i);
            #1;
            if (u_if.comp_done_o) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (c == 10 || c == 40) begin
                u_if.comp_data_i  = {64'sd1, 64'sd1, 64'sd1, 64'sd1};
                u_if.comp_shift_i = 6'd33;
                u_if.comp_init_i  = 1'b1;
            end else begin
                u_if.comp_init_i  = 1'b0;
            end
        end
        check("busy_init dones", 64'(ndone), 64'd1);
        check("busy_init latency", 64'(lat), 64'(c_lat));
        check("busy_init quo_md", 64'(u_if.comp_quo_o[1]), 64'h0001_8000);
        check("busy_init shift", 64'(u_if.comp_shift_o), 64'd5);

        // Init accepted in the done cycle.
        issue(3, 2, -7, 4, 6'd5);
        wait_done(lat);
        check("b2b first", 64'(lat), 64'(c_lat));
        issue(1, 4, -1, 4, 6'd3);
        wait_done(lat);
        check("b2b second", 64'(lat), 64'(c_lat));
        check("b2b quo_md", 64'(u_if.comp_quo_o[1]), 64'h0000_4000);
        check("b2b quo_lc", 64'(u_if.comp_quo_o[0]), 64'hFFFF_C000);
        check("b2b shift", 64'(u_if.comp_shift_o), 64'd3);

        // Reset mid-calculation aborts without a done.
        issue(3, 2, -7, 4, 6'd5);
        repeat (32) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("abort busy", 64'(u_if.comp_busy_o), 64'd0);
        check("abort quo", 64'(u_if.comp_quo_o), 64'd0);
        check("abort dz_ovf", 64'({u_if.comp_dz_o, u_if.comp_ovf_o}), 64'd0);
        check("abort shift", 64'(u_if.comp_shift_o), 64'd0);
        ndone = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk_i);
            #1;
            if (u_if.comp_done_o) ndone++;
        end
        check("abort no_done", 64'(ndone), 64'd0);
        run_vec("after_abort", 3, 2, -7, 4, 6'd5, 32'h0001_8000, 32'hFFFE_4000, 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
